// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct/ALU constants, FSM state and instruction-class types for multicycle_control.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [3:0] {
    CLS_RALU, CLS_SHIFT, CLS_ADDI, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_JR, CLS_ILLEGAL
  } cls_t;
  typedef struct packed {
    cls_t       cls;
    logic       ri;
    logic       lw;
    logic       shift;
    logic       srl;
    logic       jal;
    logic       jr;
    logic       jjrjal;
    logic       bne;
    logic [2:0] op;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct to instruction class, mux selects and ALU op; bne legal only with CTRL_BNE_EN.
module ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    ctrl.cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE:
        case (funct)
          F_ADD: begin ctrl.cls = CLS_RALU; ctrl.op = ALU_ADD; end
          F_SUB: begin ctrl.cls = CLS_RALU; ctrl.op = ALU_SUB; end
          F_AND: begin ctrl.cls = CLS_RALU; ctrl.op = ALU_AND; end
          F_OR:  begin ctrl.cls = CLS_RALU; ctrl.op = ALU_OR;  end
          F_SLT: begin ctrl.cls = CLS_RALU; ctrl.op = ALU_SLT; end
          F_SLL: begin ctrl.cls = CLS_SHIFT; ctrl.shift = 1'b1; end
          F_SRL: begin ctrl.cls = CLS_SHIFT; ctrl.shift = 1'b1; ctrl.srl = 1'b1; end
          F_JR:  begin ctrl.cls = CLS_JR; ctrl.jr = 1'b1; ctrl.jjrjal = 1'b1; end
          default: ctrl.cls = CLS_ILLEGAL;
        endcase
      OP_ADDI: begin ctrl.cls = CLS_ADDI;  ctrl.ri = 1'b1; ctrl.op = ALU_ADD; end
      OP_LW:   begin ctrl.cls = CLS_LOAD;  ctrl.ri = 1'b1; ctrl.lw = 1'b1; ctrl.op = ALU_ADD; end
      OP_SW:   begin ctrl.cls = CLS_STORE; ctrl.ri = 1'b1; ctrl.op = ALU_ADD; end
      OP_BEQ:  begin ctrl.cls = CLS_BRANCH; ctrl.ri = 1'b1; ctrl.op = ALU_SUB; end
`ifdef CTRL_BNE_EN
      OP_BNE:  begin ctrl.cls = CLS_BRANCH; ctrl.ri = 1'b1; ctrl.bne = 1'b1; ctrl.op = ALU_SUB; end
`else
      OP_BNE:  ctrl.cls = CLS_ILLEGAL;
`endif
      OP_J:    begin ctrl.cls = CLS_JUMP; ctrl.jjrjal = 1'b1; end
      OP_JAL:  begin ctrl.cls = CLS_JAL; ctrl.jal = 1'b1; ctrl.jjrjal = 1'b1; end
      default: ctrl.cls = CLS_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with latched selects and one-shot strobes.
// Optional CTRL_BNE_EN macro (see ctrl_decode) enables bne.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic       JBEQ,
  output logic       JJRJAL,
  output logic       JAL,
  output logic       JR,
  output logic       RI,
  output logic       LW,
  output logic       SHIFT,
  output logic       SRL,
  output logic [2:0] op,
  output logic       writeReg,
  output logic       writeMem,
  output logic       pcEn,
  output logic       memReq,
  output logic       illegal
);
  state_t state, nxt;
  ctrl_t  cur, dec;
  logic   wr_q, pc_q, ill_q, sw_done;
  ctrl_decode u_dec (.opcode(opcode), .funct(funct), .ctrl(dec));
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = (cur.cls inside {CLS_LOAD, CLS_STORE}) ? S_MEM :
                      (cur.cls inside {CLS_RALU, CLS_SHIFT, CLS_ADDI}) ? S_WB : S_FETCH;
      S_MEM:    nxt = !memReady ? S_MEM : (cur.cls == CLS_LOAD) ? S_WB : S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end
  // Strobes are registered one edge early so they appear in the cycle of the target state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      cur    <= '0;
      wr_q   <= 1'b0;
      pc_q   <= 1'b0;
      ill_q  <= 1'b0;
      memReq <= 1'b0;
    end else begin
      state  <= nxt;
      if (state == S_FETCH) cur <= dec;
      wr_q   <= (nxt == S_WB) || (state == S_DECODE && cur.cls == CLS_JAL);
      pc_q   <= (nxt == S_WB) || (state == S_DECODE &&
                cur.cls inside {CLS_BRANCH, CLS_JUMP, CLS_JAL, CLS_JR, CLS_ILLEGAL});
      ill_q  <= state == S_DECODE && cur.cls == CLS_ILLEGAL;
      memReq <= nxt == S_MEM;
    end
  end
  // A store completes in the same cycle memReady arrives, so its strobes are combinational.
  assign sw_done  = state == S_MEM && memReady && cur.cls == CLS_STORE;
  assign pcEn     = pc_q | sw_done;
  assign writeMem = sw_done;
  assign writeReg = wr_q;
  assign illegal  = ill_q;
  assign JBEQ     = state != S_FETCH && cur.cls == CLS_BRANCH && (zero ^ cur.bne);
  assign JJRJAL   = cur.jjrjal;
  assign JAL      = cur.jal;
  assign JR       = cur.jr;
  assign RI       = cur.ri;
  assign LW       = cur.lw;
  assign SHIFT    = cur.shift;
  assign SRL      = cur.srl;
  assign op       = cur.op;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed plus random instructions checked against a per-instruction timing/select model.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst, zero, memReady;
  logic [5:0] opcode, funct;
  logic       JBEQ, JJRJAL, JAL, JR, RI, LW, SHIFT, SRL;
  logic [2:0] op;
  logic       writeReg, writeMem, pcEn, memReq, illegal;
  int total = 0;
  int bad = 0;
  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .memReady(memReady),
    .JBEQ(JBEQ), .JJRJAL(JJRJAL), .JAL(JAL), .JR(JR), .RI(RI), .LW(LW), .SHIFT(SHIFT), .SRL(SRL),
    .op(op), .writeReg(writeReg), .writeMem(writeMem), .pcEn(pcEn), .memReq(memReq), .illegal(illegal)
  );
  always #5 clk = ~clk;
`ifdef CTRL_BNE_EN
  localparam bit BNE_OK = 1'b1;
`else
  localparam bit BNE_OK = 1'b0;
`endif
  int t_op [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 8, 35, 43, 4, 5, 2, 3};
  int t_fn [15] = '{32, 34, 36, 37, 42, 0, 2, 8, 0, 0, 0, 0, 0, 0, 0};
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_sel"}, {JJRJAL, JAL, JR}, 3'b000);
    chk({tag, "_sel2"}, {RI, LW, SHIFT}, 3'b000);
    chk({tag, "_srl_jbeq"}, {1'b0, SRL, JBEQ}, 3'b000);
    chk({tag, "_op"}, op, 3'b000);
    chk({tag, "_wr"}, {writeReg, writeMem, pcEn}, 3'b000);
    chk({tag, "_mem_ill"}, {1'b0, memReq, illegal}, 3'b000);
  endtask
  task automatic run(input int opc, input int fn, input int waits, input int zmode, input int abort_at);
    bit r_ok, alu, shf, jr_i, br, is_bne, legal, mem_i, wreg, sw_i, inmem, last, opchk;
    int len;
    logic [2:0] exp_op;
    alu    = opc == 0 && fn inside {32, 34, 36, 37, 42};
    shf    = opc == 0 && fn inside {0, 2};
    jr_i   = opc == 0 && fn == 8;
    r_ok   = alu || shf || jr_i;
    is_bne = opc == 5;
    br     = opc == 4 || (is_bne && BNE_OK);
    legal  = r_ok || br || opc inside {8, 35, 43, 2, 3};
    mem_i  = opc inside {35, 43};
    sw_i   = opc == 43;
    wreg   = alu || shf || opc inside {8, 35, 3};
    len    = (alu || shf || opc == 8 || sw_i) ? 4 + (sw_i ? waits : 0) : (opc == 35) ? 5 + waits : 3;
    opchk  = alu || br || opc inside {8, 35, 43};
    exp_op = fn == 32 ? 3'b010 : fn == 34 ? 3'b110 : fn == 36 ? 3'b000 : fn == 37 ? 3'b001 : 3'b111;
    if (!alu) exp_op = br ? 3'b110 : 3'b010;
    for (int k = 1; k <= len; k++) begin
      #1;
      if (k == 1) begin opcode = 6'(opc); funct = 6'(fn); end
      zero = zmode == 2 ? 1'($urandom) : 1'(zmode);
      inmem = mem_i && k >= 4 && k <= 4 + waits;
      memReady = inmem ? (k == 4 + waits) : 1'($urandom);
      if (k == abort_at) begin rst = 1'b1; memReady = 1'b1; end
      @(negedge clk);
      if (k == abort_at) begin
        chk_idle("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      last = k == len;
      chk("pcEn", pcEn, last);
      chk("writeReg", writeReg, last && wreg);
      chk("writeMem", writeMem, last && sw_i);
      chk("illegal", illegal, last && !legal);
      chk("memReq", memReq, inmem);
      if (k >= 2) begin
        chk("RI", RI, legal && (opc inside {8, 35, 43, 4} || br));
        chk("LW", LW, opc == 35);
        chk("SHIFT", SHIFT, shf);
        chk("SRL", SRL, shf && fn == 2);
        chk("JAL", JAL, opc == 3);
        chk("JR", JR, jr_i);
        chk("JJRJAL", JJRJAL, jr_i || opc inside {2, 3});
        chk("JBEQ", JBEQ, br && (zero ^ is_bne));
        if (opchk) chk("op", op, exp_op);
      end
      @(posedge clk);
    end
  endtask
  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; memReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    run(0, 32, 0, 2, 0);
    run(35, 17, 3, 2, 0);
    run(4, 0, 0, 1, 0);
    run(4, 0, 0, 0, 0);
    run(5, 0, 0, 0, 0);
    run(3, 0, 0, 2, 0);
    run(0, 8, 0, 2, 0);
    run(43, 0, 4, 2, 6);
    run(0, 34, 0, 2, 0);
    run(43, 5, 0, 2, 0);
    run(0, 63, 0, 2, 0);
    for (int i = 0; i < 300; i++) begin
      int idx;
      idx = $urandom_range(0, 15);
      if (idx == 15) run($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3), 2, 0);
      else run(t_op[idx], t_op[idx] == 0 ? t_fn[idx] : $urandom_range(0, 63), $urandom_range(0, 3), 2, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit that drives the control inputs of `data_path` from its `opcode`, `funct` and `zero` outputs. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and holds mux selects stable for the whole instruction. It strobes `writeReg`, `writeMem` and a PC-update enable exactly once per instruction. A ready handshake lets the data memory take a variable number of cycles.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `opcode`  in  6  instruction bits [31:26] from `data_path`.
- `funct`  in  6  instruction bits [5:0] from `data_path`.
- `zero`  in  1  ALU zero flag from `data_path`.
- `memReady`  in  1  data memory has completed the current access.
- `JBEQ, JJRJAL, JAL, JR, RI, LW, SHIFT, SRL`  out  1 each  datapath mux selects.
- `op`  out  3  ALU operation.
- `writeReg`, `writeMem`  out  1 each  single-cycle write strobes.
- `pcEn`  out  1  single-cycle PC load strobe.
- `memReq`  out  1  data memory access in progress (level).
- `illegal`  out  1  single-cycle pulse for an unsupported opcode/funct.

## Operation
- Supported instructions:
  - R-type (opcode 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010, jr 001000.
  - I-type and jumps: addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- ALU `op` encoding: and 000, or 001, add 010, sub 110, slt 111.
- States: FETCH → DECODE → EXEC → (MEM) → (WB) → FETCH.
- FETCH: one settle cycle; outputs idle.
- DECODE: registers the instruction class plus all selects and `op` from `opcode`/`funct`. These registered values stay constant until the next DECODE.
- Select rules:
  - `RI` = addi/lw/sw/beq/bne.
  - `op` = add for addi/lw/sw, sub for beq/bne, per funct for R-type.
  - `SHIFT` = sll/srl; `SRL` = srl.
  - `LW` = lw; `JAL` = jal.
  - `JR` = jr; `JJRJAL` = j/jal/jr.
- `JBEQ` is combinational: branch class AND (`zero` XOR isBne). It is 0 outside branch instructions.
- Final state per class, with its strobes:
  - R-type ALU/shift, addi: EXEC → WB. `writeReg` = `pcEn` = 1 in WB.
  - lw: EXEC → MEM (wait) → WB. `writeReg` = `pcEn` = 1 in WB.
  - sw: EXEC → MEM (wait). `writeMem` = `pcEn` = 1 in the MEM cycle where `memReady` = 1.
  - beq/bne/j/jr: `pcEn` = 1 in EXEC.
  - jal: `pcEn` = `writeReg` = 1 in EXEC.
  - Illegal opcode/funct: `pcEn` = `illegal` = 1 in EXEC. No writes occur (treated as a NOP).
- MEM: `memReq` = 1. The FSM stays in MEM while `memReady` = 0, with no bound on the wait. `memReady` outside MEM is ignored.

## Timing
- Reset: state = FETCH; all outputs 0, with `op` = 000.
- Reset asserted mid-instruction aborts it immediately: no strobe fires and the PC is not updated.
- Cycles per instruction (`memReady` high on the first MEM cycle):
  - R-type/addi: 4.
  - lw: 5.
  - sw: 4.
  - branch/jump/illegal: 3.
  - Each MEM wait cycle adds 1.
- `writeReg`, `writeMem`, `pcEn` and `illegal` are each high for exactly one cycle per instruction and are never asserted in FETCH or DECODE.
- Mux selects and `op` change only on the DECODE edge, so the datapath sees them stable for the rest of the instruction.

## Configuration
- `CTRL_BNE_EN` defined: bne (000101) is decoded as a branch taken when `zero` = 0.
- `CTRL_BNE_EN` undefined: opcode 000101 is illegal; it pulses `illegal` and never branches.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - ALU op constants;
  - state enum (FETCH, DECODE, EXEC, MEM, WB);
  - instruction-class enum (RALU, SHIFT, ADDI, LOAD, STORE, BRANCH, JUMP, JAL, JR, ILLEGAL).
- Sub-module `ctrl_decode` is a purely combinational opcode/funct → class/selects/op decoder. `multicycle_control` contains the FSM, the DECODE registers and the strobe generation.

## Test plan
- add (opcode 0, funct 100000) → selects RI=0, op=010 from cycle 2; `writeReg` and `pcEn` pulse together in cycle 4 only.
- lw (100011), `memReady` low for 3 MEM cycles → `memReq` high for 4 cycles, LW=1, `writeReg`/`pcEn` in cycle 8; total 8 cycles.
- beq (000100) with zero=1 → JBEQ=1 and `pcEn` in cycle 3. With zero=0 → JBEQ=0 and `pcEn` still pulses.
- bne (000101) with zero=0 → JBEQ=1 when built with `CTRL_BNE_EN`. Without the macro → `illegal` and `pcEn` pulse in cycle 3, JBEQ=0.
- jal (000011) → JAL=1, JJRJAL=1, `writeReg` and `pcEn` pulse in cycle 3. jr (funct 001000) → JR=1, JJRJAL=1, no `writeReg`.
- sw with `rst` asserted in the MEM wait → outputs 0 immediately, no `writeMem`. After release, execution restarts from FETCH.
